// File: rtl/axi_slave_connector_reg.sv
// Flat s_axi_* slave ports to axi_conf req/resp structs, with per-channel register slices,
// AW atop forwarding and per-direction outstanding-transaction admission control.
package axi_conf;
  localparam int ID_W   = 8;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = DATA_W / 8;
  localparam int USER_W = 1;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [5:0]        atop;
    logic [USER_W-1:0] user;
  } aw_chan_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [STRB_W-1:0] strb;
    logic              last;
    logic [USER_W-1:0] user;
  } w_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [1:0]        resp;
    logic [USER_W-1:0] user;
  } b_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic              lock;
    logic [3:0]        cache;
    logic [2:0]        prot;
    logic [3:0]        qos;
    logic [3:0]        region;
    logic [USER_W-1:0] user;
  } ar_chan_t;

  typedef struct packed {
    logic [ID_W-1:0]   id;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [USER_W-1:0] user;
  } r_chan_t;

  typedef struct packed {
    aw_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ar_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } resp_t;
endpackage

// Valid/ready contract on both sides: a beat moves on a clock edge where valid and ready are
// both high; valid never waits for ready, and payload stays stable until the beat is taken.
module axi_reg_slice #(
  parameter int WIDTH = 8,
  parameter int TYPE  = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             empty
);
  if (TYPE == 0) begin : g_bypass
    assign out_valid = in_valid;
    assign out_data  = in_data;
    assign in_ready  = out_ready;
    assign empty     = 1'b1;
  end else if (TYPE == 1) begin : g_simple
    logic             full;
    logic [WIDTH-1:0] data_q;
    assign in_ready  = ~full | out_ready;
    assign out_valid = full;
    assign out_data  = data_q;
    assign empty     = ~full;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) full <= 1'b0;
      else if (in_valid && in_ready) full <= 1'b1;
      else if (out_ready) full <= 1'b0;
    end
    always_ff @(posedge clk) begin
      if (in_valid && in_ready) data_q <= in_data;
    end
  end else begin : g_skid
    logic             main_valid, skid_valid, ready_q;
    logic [WIDTH-1:0] main_data, skid_data;
    assign in_ready  = ready_q;
    assign out_valid = main_valid;
    assign out_data  = main_data;
    assign empty     = ~main_valid & ~skid_valid;
    // ready_q mirrors ~skid_valid, except it is held low for the duration of reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        main_valid <= 1'b0;
        skid_valid <= 1'b0;
        ready_q    <= 1'b0;
      end else if (skid_valid) begin
        if (out_ready) begin
          skid_valid <= 1'b0;
          ready_q    <= 1'b1;
        end
      end else begin
        ready_q <= 1'b1;
        if (in_valid && ready_q) begin
          if (!main_valid || out_ready) main_valid <= 1'b1;
          else begin
            skid_valid <= 1'b1;
            ready_q    <= 1'b0;
          end
        end else if (out_ready) begin
          main_valid <= 1'b0;
        end
      end
    end
    always_ff @(posedge clk) begin
      if (skid_valid) begin
        if (out_ready) main_data <= skid_data;
      end else if (in_valid && ready_q) begin
        if (!main_valid || out_ready) main_data <= in_data;
        else skid_data <= in_data;
      end
    end
  end
endmodule

module axi_slave_connector_reg #(
  parameter int DATA_WIDTH         = 32,
  parameter int ADDR_WIDTH         = 32,
  parameter int STRB_WIDTH         = DATA_WIDTH / 8,
  parameter int ID_WIDTH           = 8,
  parameter int AWUSER_WIDTH       = 1,
  parameter int WUSER_WIDTH        = 1,
  parameter int BUSER_WIDTH        = 1,
  parameter int ARUSER_WIDTH       = 1,
  parameter int RUSER_WIDTH        = 1,
  parameter int AW_REG_TYPE        = 2,
  parameter int W_REG_TYPE         = 2,
  parameter int B_REG_TYPE         = 2,
  parameter int AR_REG_TYPE        = 2,
  parameter int R_REG_TYPE         = 2,
  parameter int MAX_WR_OUTSTANDING = 16,
  parameter int MAX_RD_OUTSTANDING = 16,
  parameter int CNT_WIDTH          = $clog2((MAX_WR_OUTSTANDING > MAX_RD_OUTSTANDING ?
                                             MAX_WR_OUTSTANDING : MAX_RD_OUTSTANDING) + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awlock,
  input  logic [3:0]              s_axi_awcache,
  input  logic [2:0]              s_axi_awprot,
  input  logic [3:0]              s_axi_awqos,
  input  logic [3:0]              s_axi_awregion,
  input  logic [AWUSER_WIDTH-1:0] s_axi_awuser,
  input  logic [5:0]              s_axi_awatop,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [STRB_WIDTH-1:0]   s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic [WUSER_WIDTH-1:0]  s_axi_wuser,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic [BUSER_WIDTH-1:0]  s_axi_buser,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arlock,
  input  logic [3:0]              s_axi_arcache,
  input  logic [2:0]              s_axi_arprot,
  input  logic [3:0]              s_axi_arqos,
  input  logic [3:0]              s_axi_arregion,
  input  logic [ARUSER_WIDTH-1:0] s_axi_aruser,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic [RUSER_WIDTH-1:0]  s_axi_ruser,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output axi_conf::req_t          axi_req_o,
  input  axi_conf::resp_t         axi_resp_i,
  output logic [CNT_WIDTH-1:0]    wr_outstanding_o,
  output logic [CNT_WIDTH-1:0]    rd_outstanding_o,
  output logic                    idle_o
);
  localparam logic [CNT_WIDTH-1:0] WR_MAX = CNT_WIDTH'(MAX_WR_OUTSTANDING);
  localparam logic [CNT_WIDTH-1:0] RD_MAX = CNT_WIDTH'(MAX_RD_OUTSTANDING);

  axi_conf::aw_chan_t aw_in, aw_out;
  axi_conf::w_chan_t  w_in, w_out;
  axi_conf::b_chan_t  b_out;
  axi_conf::ar_chan_t ar_in, ar_out;
  axi_conf::r_chan_t  r_out;
  logic aw_in_ready, aw_out_valid, aw_empty, w_out_valid, w_empty, b_in_ready, b_empty;
  logic ar_in_ready, ar_out_valid, ar_empty, r_in_ready, r_empty;
  logic [CNT_WIDTH-1:0] wr_cnt, rd_cnt;
  logic wr_full, rd_full, wr_inc, wr_dec, rd_inc, rd_dec;

  always_comb begin
    aw_in = '{id: s_axi_awid, addr: s_axi_awaddr, len: s_axi_awlen, size: s_axi_awsize,
              burst: s_axi_awburst, lock: s_axi_awlock, cache: s_axi_awcache,
              prot: s_axi_awprot, qos: s_axi_awqos, region: s_axi_awregion,
              atop: s_axi_awatop, user: s_axi_awuser};
    w_in  = '{data: s_axi_wdata, strb: s_axi_wstrb, last: s_axi_wlast, user: s_axi_wuser};
    ar_in = '{id: s_axi_arid, addr: s_axi_araddr, len: s_axi_arlen, size: s_axi_arsize,
              burst: s_axi_arburst, lock: s_axi_arlock, cache: s_axi_arcache,
              prot: s_axi_arprot, qos: s_axi_arqos, region: s_axi_arregion,
              user: s_axi_aruser};
  end

  // Admission gate uses only the registered counts, so it adds no ready-to-ready path.
  assign wr_full       = (wr_cnt == WR_MAX);
  assign rd_full       = (rd_cnt == RD_MAX);
  assign s_axi_awready = aw_in_ready & ~wr_full;
  assign s_axi_arready = ar_in_ready & ~rd_full;

  axi_reg_slice #(.WIDTH($bits(axi_conf::aw_chan_t)), .TYPE(AW_REG_TYPE)) u_aw (
    .clk, .rst, .in_valid(s_axi_awvalid & ~wr_full), .in_ready(aw_in_ready), .in_data(aw_in),
    .out_valid(aw_out_valid), .out_ready(axi_resp_i.aw_ready), .out_data(aw_out), .empty(aw_empty));
  axi_reg_slice #(.WIDTH($bits(axi_conf::w_chan_t)), .TYPE(W_REG_TYPE)) u_w (
    .clk, .rst, .in_valid(s_axi_wvalid), .in_ready(s_axi_wready), .in_data(w_in),
    .out_valid(w_out_valid), .out_ready(axi_resp_i.w_ready), .out_data(w_out), .empty(w_empty));
  axi_reg_slice #(.WIDTH($bits(axi_conf::b_chan_t)), .TYPE(B_REG_TYPE)) u_b (
    .clk, .rst, .in_valid(axi_resp_i.b_valid), .in_ready(b_in_ready), .in_data(axi_resp_i.b),
    .out_valid(s_axi_bvalid), .out_ready(s_axi_bready), .out_data(b_out), .empty(b_empty));
  axi_reg_slice #(.WIDTH($bits(axi_conf::ar_chan_t)), .TYPE(AR_REG_TYPE)) u_ar (
    .clk, .rst, .in_valid(s_axi_arvalid & ~rd_full), .in_ready(ar_in_ready), .in_data(ar_in),
    .out_valid(ar_out_valid), .out_ready(axi_resp_i.ar_ready), .out_data(ar_out), .empty(ar_empty));
  axi_reg_slice #(.WIDTH($bits(axi_conf::r_chan_t)), .TYPE(R_REG_TYPE)) u_r (
    .clk, .rst, .in_valid(axi_resp_i.r_valid), .in_ready(r_in_ready), .in_data(axi_resp_i.r),
    .out_valid(s_axi_rvalid), .out_ready(s_axi_rready), .out_data(r_out), .empty(r_empty));

  always_comb begin
    axi_req_o          = '0;
    axi_req_o.aw       = aw_out;
    axi_req_o.aw_valid = aw_out_valid;
    axi_req_o.w        = w_out;
    axi_req_o.w_valid  = w_out_valid;
    axi_req_o.b_ready  = b_in_ready;
    axi_req_o.ar       = ar_out;
    axi_req_o.ar_valid = ar_out_valid;
    axi_req_o.r_ready  = r_in_ready;
  end

  assign s_axi_bid   = b_out.id;
  assign s_axi_bresp = b_out.resp;
  assign s_axi_buser = b_out.user;
  assign s_axi_rid   = r_out.id;
  assign s_axi_rdata = r_out.data;
  assign s_axi_rresp = r_out.resp;
  assign s_axi_rlast = r_out.last;
  assign s_axi_ruser = r_out.user;

  assign wr_inc = s_axi_awvalid & s_axi_awready;
  assign wr_dec = s_axi_bvalid & s_axi_bready;
  assign rd_inc = s_axi_arvalid & s_axi_arready;
  assign rd_dec = s_axi_rvalid & s_axi_rready & s_axi_rlast;

  // A decrement at zero is a protocol violation; the count saturates instead of wrapping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_cnt <= '0;
      rd_cnt <= '0;
    end else begin
      if (wr_inc && !wr_dec) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
      else if (!wr_inc && wr_dec && wr_cnt != '0) wr_cnt <= wr_cnt - CNT_WIDTH'(1);
      if (rd_inc && !rd_dec) rd_cnt <= rd_cnt + CNT_WIDTH'(1);
      else if (!rd_inc && rd_dec && rd_cnt != '0) rd_cnt <= rd_cnt - CNT_WIDTH'(1);
    end
  end

  assign wr_outstanding_o = wr_cnt;
  assign rd_outstanding_o = rd_cnt;
  assign idle_o = (wr_cnt == '0) & (rd_cnt == '0) & aw_empty & w_empty & b_empty & ar_empty & r_empty;

  wr_underflow_a: assert property (@(posedge clk) disable iff (rst) !(wr_dec && wr_cnt == '0));
  rd_underflow_a: assert property (@(posedge clk) disable iff (rst) !(rd_dec && rd_cnt == '0));
endmodule

// File: tb/tb_axi_slave_connector_reg.sv
// Directed bench for axi_slave_connector_reg: skid throughput, W backpressure,
// write admission limit, read tracking and asynchronous reset with a held AW beat.
module tb_axi_slave_connector_reg;
  logic        clk, rst;
  logic [7:0]  s_axi_awid, s_axi_awlen, s_axi_arid, s_axi_arlen, s_axi_bid, s_axi_rid;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [2:0]  s_axi_awsize, s_axi_awprot, s_axi_arsize, s_axi_arprot;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awlock, s_axi_arlock, s_axi_wlast, s_axi_rlast;
  logic [3:0]  s_axi_awcache, s_axi_awqos, s_axi_awregion, s_axi_wstrb;
  logic [3:0]  s_axi_arcache, s_axi_arqos, s_axi_arregion;
  logic [0:0]  s_axi_awuser, s_axi_wuser, s_axi_buser, s_axi_aruser, s_axi_ruser;
  logic [5:0]  s_axi_awatop;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wvalid, s_axi_wready, s_axi_bvalid, s_axi_bready;
  logic        s_axi_arvalid, s_axi_arready, s_axi_rvalid, s_axi_rready;
  axi_conf::req_t  axi_req_o;
  axi_conf::resp_t axi_resp_i;
  logic [2:0]  wr_outstanding_o, rd_outstanding_o;
  logic        idle_o;

  int n_checks = 0, n_errors = 0, cyc = 0, last_w_edge = 0, w_extra = 0, aw_extra = 0;
  logic [31:0] exp_w_q[$];
  logic [37:0] exp_aw_q[$];

  axi_slave_connector_reg #(.MAX_WR_OUTSTANDING(2), .MAX_RD_OUTSTANDING(4), .CNT_WIDTH(3)) dut (
    .clk, .rst,
    .s_axi_awid, .s_axi_awaddr, .s_axi_awlen, .s_axi_awsize, .s_axi_awburst, .s_axi_awlock,
    .s_axi_awcache, .s_axi_awprot, .s_axi_awqos, .s_axi_awregion, .s_axi_awuser, .s_axi_awatop,
    .s_axi_awvalid, .s_axi_awready,
    .s_axi_wdata, .s_axi_wstrb, .s_axi_wlast, .s_axi_wuser, .s_axi_wvalid, .s_axi_wready,
    .s_axi_bid, .s_axi_bresp, .s_axi_buser, .s_axi_bvalid, .s_axi_bready,
    .s_axi_arid, .s_axi_araddr, .s_axi_arlen, .s_axi_arsize, .s_axi_arburst, .s_axi_arlock,
    .s_axi_arcache, .s_axi_arprot, .s_axi_arqos, .s_axi_arregion, .s_axi_aruser,
    .s_axi_arvalid, .s_axi_arready,
    .s_axi_rid, .s_axi_rdata, .s_axi_rresp, .s_axi_rlast, .s_axi_ruser, .s_axi_rvalid, .s_axi_rready,
    .axi_req_o, .axi_resp_i, .wr_outstanding_o, .rd_outstanding_o, .idle_o);

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // scoreboard monitors: sampled mid-cycle, the values seen here are what the next edge takes
  always @(negedge clk) begin
    if (!rst) begin
      if (axi_req_o.w_valid && axi_resp_i.w_ready) begin
        if (exp_w_q.size() == 0) w_extra++;
        else check("w_data", 64'(axi_req_o.w.data), 64'(exp_w_q.pop_front()));
        last_w_edge = cyc + 1;
      end
      if (axi_req_o.aw_valid && axi_resp_i.aw_ready) begin
        if (exp_aw_q.size() == 0) aw_extra++;
        else check("aw_atop_addr", 64'({axi_req_o.aw.atop, axi_req_o.aw.addr}), 64'(exp_aw_q.pop_front()));
      end
    end
  end

  // drivers
  task automatic set_aw(input logic [31:0] addr, input logic [5:0] atop);
    s_axi_awaddr  = addr;
    s_axi_awatop  = atop;
    s_axi_awvalid = 1'b1;
  endtask

  task automatic send_aw(input logic [31:0] addr, input logic [5:0] atop, output bit ok);
    set_aw(addr, atop);
    exp_aw_q.push_back({atop, addr});
    ok = 1'b0;
    for (int k = 0; k < 8 && !ok; k++) begin
      ok = s_axi_awready;
      tick();
    end
    s_axi_awvalid = 1'b0;
  endtask

  task automatic return_b(input logic [7:0] id);
    axi_resp_i.b_valid = 1'b1;
    axi_resp_i.b.id    = id;
    axi_resp_i.b.resp  = 2'b10;
    tick();
    axi_resp_i.b_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    bit ok, rdy;
    int stalls, start;
    rst = 1'b1;
    s_axi_awid = 8'h01; s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'd2; s_axi_awburst = 2'b01;
    s_axi_awlock = 1'b0; s_axi_awcache = '0; s_axi_awprot = '0; s_axi_awqos = '0; s_axi_awregion = '0;
    s_axi_awuser = '0; s_axi_awatop = '0; s_axi_awvalid = 1'b0;
    s_axi_wdata = '0; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b0; s_axi_wuser = '0; s_axi_wvalid = 1'b0;
    s_axi_bready = 1'b1;
    s_axi_arid = 8'h02; s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'd2; s_axi_arburst = 2'b01;
    s_axi_arlock = 1'b0; s_axi_arcache = '0; s_axi_arprot = '0; s_axi_arqos = '0; s_axi_arregion = '0;
    s_axi_aruser = '0; s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    axi_resp_i = '0;
    axi_resp_i.aw_ready = 1'b1; axi_resp_i.w_ready = 1'b1; axi_resp_i.ar_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    tick();

    // reset state
    check("rst_idle", 64'(idle_o), 64'd1);
    check("rst_wr_cnt", 64'(wr_outstanding_o), 64'd0);
    check("rst_rd_cnt", 64'(rd_outstanding_o), 64'd0);
    check("rst_awready", 64'(s_axi_awready), 64'd1);
    check("rst_wready", 64'(s_axi_wready), 64'd1);
    check("rst_w_valid", 64'(axi_req_o.w_valid), 64'd0);
    check("rst_bvalid", 64'(s_axi_bvalid), 64'd0);

    // 64 back-to-back W beats, downstream always ready
    stalls = 0;
    start = cyc;
    for (int i = 0; i < 64; i++) begin
      s_axi_wdata = 32'h1000 + 32'(i);
      s_axi_wlast = (i % 4 == 3);
      s_axi_wvalid = 1'b1;
      exp_w_q.push_back(s_axi_wdata);
      if (!s_axi_wready) stalls++;
      tick();
    end
    s_axi_wvalid = 1'b0;
    for (int k = 0; k < 10 && exp_w_q.size() != 0; k++) tick();
    check("t1_wready_stalls", 64'(stalls), 64'd0);
    check("t1_cycles", 64'(last_w_edge - start), 64'd65);
    check("t1_queue_drained", 64'(exp_w_q.size()), 64'd0);

    // W with downstream ready toggling every cycle
    for (int i = 0; i < 16; i++) begin
      s_axi_wdata = 32'h2000 + 32'(i);
      s_axi_wvalid = 1'b1;
      exp_w_q.push_back(s_axi_wdata);
      ok = 1'b0;
      for (int k = 0; k < 8 && !ok; k++) begin
        rdy = s_axi_wready;
        axi_resp_i.w_ready = ~axi_resp_i.w_ready;
        #1;
        check("t2_wready_comb", 64'(s_axi_wready), 64'(rdy));
        ok = rdy;
        tick();
      end
      check("t2_accept", 64'(ok), 64'd1);
    end
    s_axi_wvalid = 1'b0;
    for (int k = 0; k < 16; k++) begin
      axi_resp_i.w_ready = ~axi_resp_i.w_ready;
      tick();
    end
    axi_resp_i.w_ready = 1'b1;
    tick();
    check("t2_queue_drained", 64'(exp_w_q.size()), 64'd0);

    // write admission limit of 2
    send_aw(32'hA000_0000, 6'h00, ok);
    check("t3_aw1_ok", 64'(ok), 64'd1);
    check("t3_cnt1", 64'(wr_outstanding_o), 64'd1);
    send_aw(32'hA000_0100, 6'h21, ok);
    check("t3_aw2_ok", 64'(ok), 64'd1);
    check("t3_cnt2", 64'(wr_outstanding_o), 64'd2);
    set_aw(32'hA000_0200, 6'h05);
    exp_aw_q.push_back({6'h05, 32'hA000_0200});
    tick();
    tick();
    check("t3_awready_full", 64'(s_axi_awready), 64'd0);
    check("t3_cnt_full", 64'(wr_outstanding_o), 64'd2);
    check("t3_not_idle", 64'(idle_o), 64'd0);
    check("t3_b_ready", 64'(axi_req_o.b_ready), 64'd1);
    return_b(8'h5A);
    check("t3_bvalid", 64'(s_axi_bvalid), 64'd1);
    check("t3_bid", 64'(s_axi_bid), 64'h5A);
    check("t3_bresp", 64'(s_axi_bresp), 64'd2);
    check("t3_buser", 64'(s_axi_buser), 64'd0);
    check("t3_awready_still0", 64'(s_axi_awready), 64'd0);
    tick();
    check("t3_cnt_after_b", 64'(wr_outstanding_o), 64'd1);
    check("t3_awready_reopen", 64'(s_axi_awready), 64'd1);
    tick();
    s_axi_awvalid = 1'b0;
    check("t3_cnt_after_aw", 64'(wr_outstanding_o), 64'd2);

    // simultaneous AW and B handshakes at count 1
    s_axi_bready = 1'b0;
    return_b(8'h11);
    s_axi_bready = 1'b1;
    tick();
    s_axi_bready = 1'b0;
    check("t5_cnt1", 64'(wr_outstanding_o), 64'd1);
    return_b(8'h22);
    set_aw(32'hB000_0000, 6'h21);
    exp_aw_q.push_back({6'h21, 32'hB000_0000});
    check("t5_awready", 64'(s_axi_awready), 64'd1);
    check("t5_bvalid", 64'(s_axi_bvalid), 64'd1);
    s_axi_bready = 1'b1;
    tick();
    s_axi_awvalid = 1'b0;
    check("t5_cnt_simul", 64'(wr_outstanding_o), 64'd1);
    return_b(8'h33);
    tick();
    check("t5_cnt_zero", 64'(wr_outstanding_o), 64'd0);

    // read burst of 4 beats
    s_axi_araddr = 32'hC000_0040;
    s_axi_arlen = 8'd3;
    s_axi_arvalid = 1'b1;
    check("t4_arready", 64'(s_axi_arready), 64'd1);
    tick();
    s_axi_arvalid = 1'b0;
    check("t4_rd_cnt1", 64'(rd_outstanding_o), 64'd1);
    check("t4_ar_valid", 64'(axi_req_o.ar_valid), 64'd1);
    check("t4_ar_len", 64'(axi_req_o.ar.len), 64'd3);
    check("t4_not_idle", 64'(idle_o), 64'd0);
    for (int i = 0; i < 4; i++) begin
      axi_resp_i.r_valid = 1'b1;
      axi_resp_i.r.id = 8'h02;
      axi_resp_i.r.data = 32'h3000 + 32'(i);
      axi_resp_i.r.resp = 2'b00;
      axi_resp_i.r.user = 1'b1;
      axi_resp_i.r.last = (i == 3);
      tick();
    end
    axi_resp_i.r_valid = 1'b0;
    check("t4_rd_cnt_before_last", 64'(rd_outstanding_o), 64'd1);
    check("t4_rvalid", 64'(s_axi_rvalid), 64'd1);
    check("t4_rlast", 64'(s_axi_rlast), 64'd1);
    check("t4_rdata", 64'(s_axi_rdata), 64'h3003);
    check("t4_rid_resp_user", 64'({s_axi_rid, s_axi_rresp, s_axi_ruser}), 64'({8'h02, 2'b00, 1'b1}));
    tick();
    check("t4_rd_cnt0", 64'(rd_outstanding_o), 64'd0);
    check("t4_idle", 64'(idle_o), 64'd1);

    // asynchronous reset while the AW slice holds a beat
    axi_resp_i.aw_ready = 1'b0;
    set_aw(32'hD000_0000, 6'h21);
    tick();
    s_axi_awvalid = 1'b0;
    check("t6_aw_held", 64'(axi_req_o.aw_valid), 64'd1);
    check("t6_atop", 64'(axi_req_o.aw.atop), 64'h21);
    check("t6_cnt1", 64'(wr_outstanding_o), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("t6_rst_aw_valid", 64'(axi_req_o.aw_valid), 64'd0);
    check("t6_rst_cnt", 64'(wr_outstanding_o), 64'd0);
    check("t6_rst_awready", 64'(s_axi_awready), 64'd0);
    check("t6_rst_idle", 64'(idle_o), 64'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("t6_awready_before_edge", 64'(s_axi_awready), 64'd0);
    tick();
    check("t6_awready_after_edge", 64'(s_axi_awready), 64'd1);
    check("t6_idle_after", 64'(idle_o), 64'd1);
    check("t6_aw_valid_after", 64'(axi_req_o.aw_valid), 64'd0);
    axi_resp_i.aw_ready = 1'b1;
    tick();

    check("end_w_extra", 64'(w_extra), 64'd0);
    check("end_aw_extra", 64'(aw_extra), 64'd0);
    check("end_aw_queue", 64'(exp_aw_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
